// File: rtl/td4_program_loader_pkg.sv
// Shared definitions for the TD4 program loader / fetch stage.
//   state_e     : loader FSM state encoding (exported on the state port)
//   TD4_*       : default geometry of the program memory
//   *_LSB/_MSB  : opcode and immediate field positions in an instruction word
package td4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    localparam int unsigned TD4_PC_W      = 4;
    localparam int unsigned TD4_MEM_DEPTH = 16;
    localparam int unsigned TD4_INSTR_W   = 8;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 3;
    localparam int unsigned IMM_LSB = 4;
    localparam int unsigned IMM_MSB = 7;

endpackage

// File: rtl/td4_program_loader_if.sv
// Pin bundle of the TD4 program loader.
//   load_en, run_en        : mode requests (synchronous levels)
//   step_req, wr_strobe    : asynchronous pins, rising edge is the event
//   wr_data                : instruction word to be written while loading
//   pc                     : CPU program counter
//   opcode, immediate      : fetched instruction fields of mem[pc]
//   cpu_ce                 : CPU clock enable pulses
//   wr_addr, mem_full      : load progress
//   state                  : loader FSM state
// Modports: slave = loader side, master = CPU / programming side.
interface td4_program_loader_if #(
    parameter int unsigned PC_W = 4
);
    logic            load_en;
    logic            run_en;
    logic            step_req;
    logic            wr_strobe;
    logic [7:0]      wr_data;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode;
    logic [3:0]      immediate;
    logic            cpu_ce;
    logic [PC_W-1:0] wr_addr;
    logic            mem_full;
    logic [1:0]      state;

    modport slave (
        input  load_en, run_en, step_req, wr_strobe, wr_data, pc,
        output opcode, immediate, cpu_ce, wr_addr, mem_full, state
    );

    modport master (
        output load_en, run_en, step_req, wr_strobe, wr_data, pc,
        input  opcode, immediate, cpu_ce, wr_addr, mem_full, state
    );
endinterface

// File: rtl/td4_program_loader_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
//   clk, rst_n : clock and asynchronous active-low reset
//   async_in   : asynchronous pin
//   pulse      : one-cycle pulse, high 3 clk after async_in rises
module td4_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);
    // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection
    logic [2:0] sync_q;
    logic       pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 3'b000;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], async_in};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/td4_program_loader.sv
// TD4 fetch stage: 16 x 8 program memory filled from pins in LOAD, read
// combinationally at the CPU program counter, plus a clock-enable generator
// gating CPU execution (free run with divider, or single step).
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : td4_program_loader_if slave (mode requests, write pins,
//                pc in; opcode/immediate, cpu_ce, wr_addr, mem_full, state out)
module td4_program_loader
    import td4_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned PC_W      = 4,
    parameter int unsigned CE_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    td4_program_loader_if.slave   bus
);
    localparam logic [7:0]      CE_LAST  = 8'(CE_DIV - 1);
    localparam logic [PC_W-1:0] ADDR_ONE = PC_W'(1);

    logic wr_pulse;
    logic step_pulse;

    td4_edge_sync u_wr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.wr_strobe),
        .pulse    (wr_pulse)
    );

    td4_edge_sync u_step_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.step_req),
        .pulse    (step_pulse)
    );

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   ce_q, ce_d;
    logic [PC_W-1:0]        wr_addr_q, wr_addr_d;
    logic                   mem_full_q, mem_full_d;
    logic                   wr_en;
    logic [TD4_INSTR_W-1:0] mem_q [MEM_DEPTH];
    logic [TD4_INSTR_W-1:0] rd_word;

    // Next-state, divider and clock-enable
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_en) begin
                    state_d = ST_LOAD;
                end else if (bus.run_en) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_LOAD: begin
                if (!bus.load_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.load_en) begin
                    state_d = ST_LOAD;
                end else if (!bus.run_en) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = (cnt_q == CE_LAST) ? 8'd0 : 8'(cnt_q + 8'd1);
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered enable: high in the cycle the new state/count take effect
        ce_d = (state_d == ST_STEP) || ((state_d == ST_RUN) && (cnt_d == CE_LAST));
    end

    // Write pointer and fill flag; any entry into LOAD restarts the fill
    assign wr_en = (state_q == ST_LOAD) && wr_pulse;

    always_comb begin
        wr_addr_d  = wr_addr_q;
        mem_full_d = mem_full_q;
        if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
            wr_addr_d  = '0;
            mem_full_d = 1'b0;
        end else if (wr_en) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (wr_addr_q == '1) begin
                mem_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            ce_q       <= 1'b0;
            wr_addr_q  <= '0;
            mem_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ce_q       <= ce_d;
            wr_addr_q  <= wr_addr_d;
            mem_full_q <= mem_full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr_q] <= bus.wr_data;
        end
    end

    // Zero-latency fetch, live in every state
    assign rd_word       = mem_q[bus.pc];
    assign bus.opcode    = rd_word[OPC_MSB:OPC_LSB];
    assign bus.immediate = rd_word[IMM_MSB:IMM_LSB];
    assign bus.cpu_ce    = ce_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.mem_full  = mem_full_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_td4_program_loader.sv
module tb_td4_program_loader;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    td4_program_loader_if #(.PC_W(4)) bus ();

    td4_program_loader #(
        .MEM_DEPTH (16),
        .PC_W      (4),
        .CE_DIV    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        bus.wr_data   = d;
        bus.wr_strobe = 1'b1;
        repeat (5) @(negedge clk);
        bus.wr_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state);
        end
        n_checks++;
        if (bus.cpu_ce !== 1'b0) begin
            n_fail++; $display("FAIL reset_cpu_ce: got %b want 0", bus.cpu_ce);
        end
        n_checks++;
        if (bus.wr_addr !== 4'd0 || bus.mem_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr: wr_addr %0d mem_full %b want 0 0", bus.wr_addr, bus.mem_full);
        end
        for (int i = 0; i < 16; i++) begin
            bus.pc = 4'(i);
            #1;
            n_checks++;
            if (bus.opcode !== 4'h0 || bus.immediate !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_mem pc=%0d: got %h/%h want 0/0", i, bus.opcode, bus.immediate);
            end
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        bus.load_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd1) begin
            n_fail++; $display("FAIL load_enter: state %0d want 1", bus.state);
        end
        write_word(8'h13);
        write_word(8'h27);
        write_word(8'hF0);
        write_word(8'h5A);
        bus.load_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wr_addr !== 4'd4 || bus.mem_full !== 1'b0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL load_ptr: wr_addr %0d full %b state %0d want 4 0 0",
                     bus.wr_addr, bus.mem_full, bus.state);
        end
        bus.pc = 4'd2; #1;
        n_checks++;
        if (bus.opcode !== 4'h0 || bus.immediate !== 4'hF) begin
            n_fail++; $display("FAIL load_pc2: got %h/%h want 0/F", bus.opcode, bus.immediate);
        end
        bus.pc = 4'd3; #1;
        n_checks++;
        if (bus.opcode !== 4'hA || bus.immediate !== 4'h5) begin
            n_fail++; $display("FAIL load_pc3: got %h/%h want A/5", bus.opcode, bus.immediate);
        end
        bus.pc = 4'd0; #1;
        n_checks++;
        if (bus.opcode !== 4'h3 || bus.immediate !== 4'h1) begin
            n_fail++; $display("FAIL load_pc0: got %h/%h want 3/1", bus.opcode, bus.immediate);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bus.load_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.wr_addr !== 4'd0) begin
            n_fail++; $display("FAIL wrap_clear: wr_addr %0d want 0", bus.wr_addr);
        end
        for (int i = 0; i < 15; i++) write_word({4'(15 - i), 4'(i)});
        n_checks++;
        if (bus.mem_full !== 1'b0 || bus.wr_addr !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_15: full %b wr_addr %0d want 0 15", bus.mem_full, bus.wr_addr);
        end
        write_word(8'h0F);
        n_checks++;
        if (bus.mem_full !== 1'b1 || bus.wr_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_16: full %b wr_addr %0d want 1 0", bus.mem_full, bus.wr_addr);
        end
        write_word(8'hEE);
        n_checks++;
        if (bus.mem_full !== 1'b1 || bus.wr_addr !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_17: full %b wr_addr %0d want 1 1", bus.mem_full, bus.wr_addr);
        end
        bus.pc = 4'd0; #1;
        n_checks++;
        if (bus.opcode !== 4'hE || bus.immediate !== 4'hE) begin
            n_fail++; $display("FAIL wrap_pc0: got %h/%h want E/E", bus.opcode, bus.immediate);
        end
        bus.pc = 4'd5; #1;
        n_checks++;
        if (bus.opcode !== 4'h5 || bus.immediate !== 4'hA) begin
            n_fail++; $display("FAIL wrap_pc5: got %h/%h want 5/A", bus.opcode, bus.immediate);
        end
        @(negedge clk);
        bus.load_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic enter_run(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.run_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.state === 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL run_enter: timeout, state %0d want 2", bus.state);
        end
    endtask

    task automatic test_run();
        bit ok;
        int pulses;
        int last_idx;
        int bad_gap;
        pulses   = 0;
        last_idx = -1;
        bad_gap  = 0;
        enter_run(ok);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.cpu_ce === 1'b1) begin
                if (last_idx >= 0 && (k - last_idx) != 3) bad_gap++;
                if (last_idx < 0 && k != 2) bad_gap++;
                last_idx = k;
                pulses++;
            end
        end
        n_checks++;
        if (pulses != 4) begin
            n_fail++; $display("FAIL run_pulses: got %0d want 4", pulses);
        end
        n_checks++;
        if (bad_gap != 0) begin
            n_fail++; $display("FAIL run_spacing: %0d bad gaps want 0", bad_gap);
        end
        bus.load_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd1 || bus.cpu_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL run_to_load: state %0d ce %b want 1 0", bus.state, bus.cpu_ce);
        end
        bus.load_en = 1'b0;
        bus.run_en  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_step();
        bit ok;
        int extra;
        @(negedge clk);
        bus.step_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.cpu_ce !== (k == 4)) begin
                n_fail++;
                $display("FAIL step_ce cycle %0d: got %b want %b", k, bus.cpu_ce, (k == 4));
            end
        end
        bus.step_req = 1'b0;
        repeat (4) @(negedge clk);
        // Step edge during RUN must not be replayed in IDLE
        enter_run(ok);
        bus.step_req = 1'b1;
        repeat (5) @(negedge clk);
        bus.step_req = 1'b0;
        repeat (7) @(negedge clk);
        bus.run_en = 1'b0;
        @(negedge clk);
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.cpu_ce !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL step_in_run: %0d ce cycles state %0d want 0 0", extra, bus.state);
        end
    endtask

    task automatic test_edge_cases();
        bit ok;
        write_word(8'h77);
        n_checks++;
        if (bus.wr_addr !== 4'd0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_strobe_ptr: wr_addr %0d state %0d want 0 0", bus.wr_addr, bus.state);
        end
        bus.pc = 4'd0; #1;
        n_checks++;
        if (bus.opcode !== 4'hE || bus.immediate !== 4'hE) begin
            n_fail++; $display("FAIL idle_strobe_mem: got %h/%h want E/E", bus.opcode, bus.immediate);
        end
        @(negedge clk);
        bus.load_en = 1'b1;
        @(negedge clk);
        write_word(8'h11);
        n_checks++;
        if (bus.wr_addr !== 4'd1) begin
            n_fail++; $display("FAIL edge_first: wr_addr %0d want 1", bus.wr_addr);
        end
        // Strobe pulse lands in the same cycle load_en is dropped
        @(negedge clk);
        bus.wr_data   = 8'h9C;
        bus.wr_strobe = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.load_en = 1'b0;
        repeat (3) @(negedge clk);
        bus.wr_strobe = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.wr_addr !== 4'd2 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL coincident_ptr: wr_addr %0d state %0d want 2 0", bus.wr_addr, bus.state);
        end
        bus.pc = 4'd1; #1;
        n_checks++;
        if (bus.opcode !== 4'hC || bus.immediate !== 4'h9) begin
            n_fail++; $display("FAIL coincident_mem: got %h/%h want C/9", bus.opcode, bus.immediate);
        end
        // Async reset in RUN while cpu_ce is high
        enter_run(ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.cpu_ce === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL reset_run_wait: no cpu_ce within 10 cycles, want 1");
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.cpu_ce !== 1'b0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_run_async: ce %b state %0d want 0 0", bus.cpu_ce, bus.state);
        end
        bus.run_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.pc = 4'd1; #1;
        n_checks++;
        if (bus.opcode !== 4'h0 || bus.immediate !== 4'h0 || bus.wr_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_run_mem: got %h/%h wr_addr %0d want 0/0 0",
                     bus.opcode, bus.immediate, bus.wr_addr);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.run_en    = 1'b0;
        bus.step_req  = 1'b0;
        bus.wr_strobe = 1'b0;
        bus.wr_data   = 8'h00;
        bus.pc        = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_load();
        test_wrap();
        test_run();
        test_step();
        test_edge_cases();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/td4_program_loader.md
Name: td4_program_loader

Overview:
Upstream fetch stage for the TD4 CPU core. Holds a 16 x 8-bit program memory that is filled from pins while loading. In operation it presents the instruction addressed by the CPU's program counter as opcode/immediate. It also gates CPU execution through a clock-enable, with run, halt and single-step control, so the CPU no longer takes its instruction straight from the input pins.

Parameters:
MEM_DEPTH, 16, program words; must equal 2**PC_W.
PC_W, 4, program counter width.
CE_DIV, 1, in RUN, cpu_ce asserts once every CE_DIV clk cycles; legal range 1..255.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
load_en  input  1  level; request LOAD mode (synchronous to clk).
run_en  input  1  level; request free-running execution (synchronous).
step_req  input  1  asynchronous pin; each rising edge requests one instruction.
wr_strobe  input  1  asynchronous pin; each rising edge writes wr_data.
wr_data  input  8  instruction word: [3:0] opcode, [7:4] immediate.
pc  input  PC_W  CPU program counter.
opcode  output  4  mem[pc][3:0].
immediate  output  4  mem[pc][7:4].
cpu_ce  output  1  CPU clock enable; one-cycle pulses.
wr_addr  output  PC_W  next write address.
mem_full  output  1  all 16 words written since entering LOAD.
state  output  2  current FSM state.

Behaviour:
- Reset (async, rst_n=0):
  - All memory words = 8'h00.
  - wr_addr = 0, mem_full = 0, state = IDLE, cpu_ce = 0, divider counter = 0, synchronizer flops = 0.
- Synchronizers: wr_strobe and step_req each pass through 2 flops, then a rising-edge detector.
  - Edge pulse appears 3 clk after the pin rises.
  - wr_data is sampled on the pulse cycle. External contract: hold wr_data stable from 1 cycle before the strobe rises until 4 cycles after it.
- FSM states: IDLE=0, LOAD=1, RUN=2, STEP=3. Priority: load_en > run_en > step.
  - IDLE:
    - load_en=1 -> LOAD; clears wr_addr and mem_full.
    - else run_en=1 -> RUN; clears the divider counter.
    - else step edge -> STEP.
  - LOAD:
    - Each wr_strobe edge: mem[wr_addr] <= wr_data, wr_addr += 1 (mod 16).
    - The write that wraps wr_addr 15->0 sets mem_full. Further writes overwrite from 0; mem_full stays 1.
    - load_en=0 -> IDLE.
  - RUN:
    - Divider counts 0..CE_DIV-1. cpu_ce=1 in the cycle the counter equals CE_DIV-1; counter then wraps to 0.
    - CE_DIV=1 gives cpu_ce=1 every cycle.
    - load_en=1 -> LOAD; run_en=0 -> IDLE. Either exit forces cpu_ce=0 in the next cycle.
  - STEP:
    - cpu_ce=1 for exactly this one cycle, then unconditional return to IDLE.
    - A step edge arriving during STEP, RUN or LOAD is discarded, not queued.
- cpu_ce is registered and valid only in RUN/STEP; it is 0 in IDLE and LOAD.
- wr_strobe edges outside LOAD are ignored: no write, wr_addr unchanged.
- Strobe edge in the same cycle that load_en falls: the write is performed, because state is still LOAD in that cycle.
- Fetch:
  - opcode/immediate = combinational read of mem[pc]; valid in the same cycle pc changes, zero latency.
  - Driven in all states; in LOAD they reflect live memory contents, including a word written in the previous cycle.
- Reset mid-LOAD: written contents are lost (cleared to 0). Reset mid-RUN: cpu_ce drops immediately (async).

Decomposition:
- Package td4_pkg holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_RUN, ST_STEP;
  - TD4_PC_W = 4, TD4_MEM_DEPTH = 16, TD4_INSTR_W = 8;
  - opcode field slice positions.
- Sub-module td4_edge_sync: 2-flop synchronizer plus rising-edge pulse, async active-low reset. Instantiated twice, for wr_strobe and step_req.

Test Plan:
1. Reset then idle: after rst_n release, opcode=0, immediate=0, cpu_ce=0, state=0, wr_addr=0, for pc=0..15.
2. Load: load_en=1, four strobes with 8'h13, 8'h27, 8'hF0, 8'h5A, load_en=0. Required: wr_addr=4, mem_full=0; pc=2 gives opcode=0, immediate=F; pc=3 gives opcode=A, immediate=5.
3. Wrap: 17 strobes in LOAD, the 17th with 8'hEE. Required: mem_full=1 after the 16th, wr_addr=1; pc=0 reads E/E.
4. Run with CE_DIV=3: run_en=1 for 12 cycles. Required: exactly 4 cpu_ce pulses, spaced 3 cycles apart. Then load_en=1 while run_en=1: state=LOAD, cpu_ce=0 next cycle.
5. Step: in IDLE, one step_req pulse gives exactly one cpu_ce cycle, 4 clk after the pin edge. Step pulses during RUN cause no extra pulse after returning to IDLE.
6. Ignored and edge-case writes: strobe in IDLE leaves memory and wr_addr unchanged. Strobe edge coincident with load_en fall still writes. Async reset mid-RUN drops cpu_ce without a clock edge.
